// File: rtl/gcd_pkg.sv
// gcd_pkg: encodings and default width shared by the GCD core and its operand loader.
package gcd_pkg;
   localparam int GCD_WIDTH = 5;
   typedef enum logic [2:0] {CAP_A, CAP_B, LOAD, WAIT, SHOW, ERR} state_t;
   typedef enum logic [1:0] {PH_ENTER_A, PH_ENTER_B, PH_BUSY, PH_SHOW} phase_t;
   function automatic phase_t phase_of(state_t s);
      return s == CAP_A ? PH_ENTER_A :
             s == CAP_B ? PH_ENTER_B :
             (s == LOAD || s == WAIT) ? PH_BUSY : PH_SHOW;
   endfunction
endpackage

// File: rtl/gcd_operand_loader_if.sv
// gcd_operand_loader_if: operand/load/result bus between the loader (master) and the GCD core (slave).
interface gcd_operand_loader_if
   import gcd_pkg::*;
#(
   parameter int WIDTH = GCD_WIDTH
);
   logic [WIDTH-1:0] a_out;
   logic [WIDTH-1:0] b_out;
   logic [WIDTH-1:0] gcd_result;
   logic             load_n;
   logic             gcd_done;
   modport master (output a_out, b_out, load_n, input gcd_done, gcd_result);
   modport slave (input a_out, b_out, load_n, output gcd_done, gcd_result);
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: synchronises an active-low button, accepts a level after DEBOUNCE_CYCLES
// consecutive differing samples, and pulses press for one cycle on each accepted 1->0 flip.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_n,
   output logic press
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic s1, s2, level;
   logic [CW-1:0] cnt;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
         level <= 1'b1;
         cnt <= '0;
         press <= 1'b0;
      end else begin
         s1 <= btn_n;
         s2 <= s1;
         press <= 1'b0;
         if (s2 == level) cnt <= '0;
         else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt <= '0;
            level <= s2;
            press <= !s2;
         end else cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/gcd_operand_loader.sv
// gcd_operand_loader: button/switch operand entry for the GCD core; drives operands and the
// active-low load strobe, then waits (with timeout) for done and latches the result.
module gcd_operand_loader
   import gcd_pkg::*;
#(
   parameter int WIDTH = GCD_WIDTH,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int LOAD_HOLD_CYCLES = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             btn_n,
   input  logic [WIDTH-1:0] sw,
   gcd_operand_loader_if.master core,
   output logic [WIDTH-1:0] result_q,
   output logic             result_valid,
   output logic [1:0]       phase,
   output logic             timeout_err
);
   localparam int CMAX = TIMEOUT_CYCLES > LOAD_HOLD_CYCLES ? TIMEOUT_CYCLES : LOAD_HOLD_CYCLES;
   localparam int CW = $clog2(CMAX + 1);
   state_t state, nxt;
   logic press, cap_a, cap_b, done_hit, tmo, clr_err;
   logic [WIDTH-1:0] sw_s1, sw_s2, a_q, b_q;
   logic [CW-1:0] cnt;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk(clk), .reset(reset), .btn_n(btn_n), .press(press)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= CAP_A;
         cnt <= '0;
      end else begin
         state <= nxt;
         cnt <= (nxt != state) ? '0 : (cnt == CW'(CMAX) ? cnt : cnt + 1'b1);
      end
   end

   // The first WAIT cycle (cnt==0) never qualifies done: the core may still show the previous one.
   always_comb begin
      nxt = state;
      cap_a = 1'b0;
      cap_b = 1'b0;
      done_hit = 1'b0;
      tmo = 1'b0;
      clr_err = 1'b0;
      case (state)
         CAP_A: if (press) begin cap_a = 1'b1; nxt = CAP_B; end
         CAP_B: if (press) begin cap_b = 1'b1; nxt = LOAD; end
         LOAD:  if (cnt == CW'(LOAD_HOLD_CYCLES)) nxt = WAIT;
         WAIT:  if (cnt != '0 && core.gcd_done) begin done_hit = 1'b1; nxt = SHOW; end
                else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin tmo = 1'b1; nxt = ERR; end
         SHOW:  if (press) begin cap_a = 1'b1; nxt = CAP_B; end
         ERR:   if (press) begin clr_err = 1'b1; nxt = CAP_A; end
         default: nxt = CAP_A;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sw_s1 <= '0;
         sw_s2 <= '0;
         a_q <= '0;
         b_q <= '0;
         result_q <= '0;
         result_valid <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         sw_s1 <= sw;
         sw_s2 <= sw_s1;
         a_q <= cap_a ? sw_s2 : a_q;
         b_q <= cap_b ? sw_s2 : b_q;
         result_q <= done_hit ? core.gcd_result : result_q;
         result_valid <= done_hit ? 1'b1 : cap_b ? 1'b0 : result_valid;
         timeout_err <= tmo ? 1'b1 : clr_err ? 1'b0 : timeout_err;
      end
   end

   // LOAD's first cycle keeps load_n high so the fresh B operand is set up one cycle ahead.
   assign core.load_n = !(state == LOAD && cnt != '0);
   assign core.a_out = a_q;
   assign core.b_out = b_q;
   assign phase = phase_of(state);
endmodule

// File: tb/tb_gcd_operand_loader.sv
// tb_gcd_operand_loader: directed flows with a queue scoreboard checked by a negedge monitor.
module tb_gcd_operand_loader;
   localparam int W = 5;
   localparam int DB = 16;
   typedef struct {int a; int b;} load_t;
   typedef struct {bit err; int res; int dwell;} res_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic btn_n = 1'b1;
   logic [W-1:0] sw = '0;
   logic [W-1:0] result_q;
   logic result_valid, timeout_err;
   logic [1:0] phase;
   int errors = 0;
   int checks = 0;
   int core_mode = 0;
   int core_res = 0;
   int dly = 0;
   load_t load_q[$];
   res_t res_q[$];

   bit prev_ld, prev_rv, prev_te;
   int low_cnt, dwell;
   logic [W-1:0] pa, pb, la, lb;
   load_t le;
   res_t re;

   gcd_operand_loader_if #(.WIDTH(W)) core ();

   gcd_operand_loader #(
      .WIDTH(W), .DEBOUNCE_CYCLES(DB), .LOAD_HOLD_CYCLES(2), .TIMEOUT_CYCLES(64)
   ) dut (
      .clk(clk), .reset(reset), .btn_n(btn_n), .sw(sw), .core(core),
      .result_q(result_q), .result_valid(result_valid), .phase(phase), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic press_btn(input logic [W-1:0] v);
      sw = v;
      repeat (4) @(negedge clk);
      btn_n = 1'b0;
      repeat (DB + 6) @(negedge clk);
      btn_n = 1'b1;
      repeat (DB + 6) @(negedge clk);
   endtask

   task automatic wait_phase(input string name, input logic [1:0] p, input int budget);
      int n = 0;
      while (phase !== p && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(name, phase, p);
   endtask

   task automatic wait_load_low(input int budget);
      int n = 0;
      while (core.load_n !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("load_low_seen", core.load_n, 0);
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_load_n"}, core.load_n, 1);
      chk({tag, "_phase"}, phase, 0);
      chk({tag, "_valid"}, result_valid, 0);
      chk({tag, "_a"}, core.a_out, 0);
      chk({tag, "_b"}, core.b_out, 0);
      chk({tag, "_result"}, result_q, 0);
      chk({tag, "_tmo"}, timeout_err, 0);
   endtask

   // Core model: mode 0 = done 5 WAIT cycles after load, 1 = done stuck high, 2 = done stuck low.
   initial begin
      core.gcd_done = 1'b0;
      core.gcd_result = '0;
      forever begin
         @(negedge clk);
         if (core_mode == 1) begin
            core.gcd_done = 1'b1;
            core.gcd_result = W'(core_res);
         end else if (core_mode == 2 || !core.load_n) begin
            core.gcd_done = 1'b0;
            dly = 5;
         end else if (dly > 0) begin
            dly--;
            if (dly == 0) begin
               core.gcd_done = 1'b1;
               core.gcd_result = W'(core_res);
            end
         end
      end
   end

   initial begin
      prev_ld = 1'b1;
      prev_rv = 1'b0;
      prev_te = 1'b0;
      low_cnt = 0;
      dwell = 0;
      pa = '0;
      pb = '0;
      la = '0;
      lb = '0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            prev_ld = 1'b1;
            prev_rv = 1'b0;
            prev_te = 1'b0;
            low_cnt = 0;
         end else begin
            dwell++;
            if (!core.load_n) begin
               if (low_cnt == 0) begin
                  la = core.a_out;
                  lb = core.b_out;
                  chk("setup_a", la, pa);
                  chk("setup_b", lb, pb);
               end else begin
                  chk("hold_a", core.a_out, la);
                  chk("hold_b", core.b_out, lb);
               end
               low_cnt++;
            end else if (!prev_ld) begin
               dwell = 0;
               chk("load_expected", load_q.size() > 0, 1);
               if (load_q.size() > 0) begin
                  le = load_q.pop_front();
                  chk("load_a", la, le.a);
                  chk("load_b", lb, le.b);
                  chk("load_len", low_cnt, 2);
               end
               low_cnt = 0;
            end
            if ((result_valid && !prev_rv) || (timeout_err && !prev_te)) begin
               chk("result_expected", res_q.size() > 0, 1);
               if (res_q.size() > 0) begin
                  re = res_q.pop_front();
                  chk("res_err", timeout_err, re.err);
                  if (!re.err) chk("res_val", result_q, re.res);
                  chk("res_dwell", dwell, re.dwell);
               end
            end
            prev_ld = core.load_n;
            prev_rv = result_valid;
            prev_te = timeout_err;
         end
         pa = core.a_out;
         pb = core.b_out;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      #1 reset = 1'b0;
      #1 chk_reset_values("rst0");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      // Bounce: 3-cycle runs never reach the debounce count, then a clean hold gives one press.
      sw = 30;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 40; i++) begin
         btn_n = ((i / 3) % 2) != 0;
         @(negedge clk);
      end
      chk("bounce_no_press", phase, 0);
      btn_n = 1'b0;
      repeat (30) @(negedge clk);
      chk("bounce_phase", phase, 1);
      chk("bounce_a", core.a_out, 30);
      btn_n = 1'b1;
      repeat (DB + 6) @(negedge clk);
      // Full flow 30,10 -> 10
      core_mode = 0;
      core_res = 10;
      load_q.push_back('{a: 30, b: 10});
      res_q.push_back('{err: 0, res: 10, dwell: 5});
      press_btn(10);
      wait_phase("flow_phase", 3, 50);
      chk("flow_result", result_q, 10);
      chk("flow_valid", result_valid, 1);
      // SHOW press recaptures A and keeps the old result valid
      press_btn(25);
      chk("show_phase", phase, 1);
      chk("show_a", core.a_out, 25);
      chk("show_b_held", core.b_out, 10);
      chk("show_valid_held", result_valid, 1);
      // Stale done held high: captured in the second WAIT cycle
      core_mode = 1;
      core_res = 5;
      load_q.push_back('{a: 25, b: 15});
      res_q.push_back('{err: 0, res: 5, dwell: 2});
      press_btn(15);
      wait_phase("stale_phase", 3, 50);
      chk("stale_result", result_q, 5);
      // Timeout
      press_btn(7);
      core_mode = 2;
      load_q.push_back('{a: 7, b: 3});
      res_q.push_back('{err: 1, res: 0, dwell: 64});
      press_btn(3);
      wait_phase("tmo_phase", 3, 80);
      chk("tmo_err", timeout_err, 1);
      chk("tmo_valid", result_valid, 0);
      press_btn(1);
      chk("err_clear", timeout_err, 0);
      chk("err_phase", phase, 0);
      chk("err_a_held", core.a_out, 7);
      // Press during WAIT is dropped, then reset during WAIT
      press_btn(12);
      load_q.push_back('{a: 12, b: 8});
      press_btn(8);
      btn_n = 1'b0;
      repeat (DB + 6) @(negedge clk);
      chk("ign_phase", phase, 2);
      chk("ign_a", core.a_out, 12);
      chk("ign_b", core.b_out, 8);
      chk("ign_tmo", timeout_err, 0);
      reset = 1'b0;
      btn_n = 1'b1;
      #1 chk_reset_values("rst_wait");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (10) @(negedge clk);
      chk("post_rst_phase", phase, 0);
      chk("post_rst_result", result_q, 0);
      chk("post_rst_valid", result_valid, 0);
      // Reset inside the load_n low window releases load_n without a clock edge
      press_btn(9);
      sw = 6;
      repeat (4) @(negedge clk);
      btn_n = 1'b0;
      wait_load_low(40);
      #1 reset = 1'b0;
      #1 chk("rst_async_load_n", core.load_n, 1);
      chk("rst_async_phase", phase, 0);
      chk("rst_async_a", core.a_out, 0);
      btn_n = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      // Zero operands pass straight through
      core_mode = 0;
      core_res = 0;
      press_btn(0);
      chk("zero_phase_b", phase, 1);
      load_q.push_back('{a: 0, b: 0});
      res_q.push_back('{err: 0, res: 0, dwell: 5});
      press_btn(0);
      wait_phase("zero_phase", 3, 50);
      chk("zero_valid", result_valid, 1);
      chk("zero_result", result_q, 0);
      repeat (5) @(negedge clk);
      chk("load_q_drained", load_q.size(), 0);
      chk("res_q_drained", res_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
